// File: rtl/and_outputs_pkg_hdl.sv
// rtl/and_outputs_pkg_hdl.sv - shared types and defaults for the AND result responder (option: AND_OUTPUTS_PARITY_EN)
package and_outputs_pkg_hdl;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

`ifdef AND_OUTPUTS_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // Occupancy-tracking states of the result buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Result entry at the default width; FIFO entries use the same {par, data} order at any WIDTH
    typedef struct packed {
`ifdef AND_OUTPUTS_PARITY_EN
        logic                     par;
`endif
        logic [DEFAULT_WIDTH-1:0] data;
    } result_t;

endpackage

// File: rtl/and_outputs_fifo.sv
// rtl/and_outputs_fifo.sv - result buffer with level-based full/empty and a registered head
module and_outputs_fifo
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
)
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [W-1:0]     r_head;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;
    logic [W-1:0]     w_head_next;

    // A flush cycle swallows both operations; full/empty come only from the level
    assign w_push    = i_push && !i_flush && (r_level != LVL_FULL);
    assign w_pop     = i_pop && !i_flush && (r_level != '0);
    assign w_rd_next = r_rd_ptr + 1'b1;

    // Next head value: keeps o_head a plain register while still giving one-cycle latency
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_level > LVL_ONE) begin
                w_head_next = r_mem[w_rd_next];
            end else if (w_push) begin
                w_head_next = i_data;
            end
        end else if (w_push && (r_level == '0)) begin
            w_head_next = i_data;
        end
    end

    // Storage array: written at the tail on every accepted push
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, level and head register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_head <= w_head_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_ONE;
            end
        end
    end

    assign o_head  = r_head;
    assign o_level = r_level;

endmodule

// File: rtl/and_outputs_responder.sv
// rtl/and_outputs_responder.sv - AND operand responder with buffered results (option: AND_OUTPUTS_PARITY_EN adds o_out_par)
module and_outputs_responder
    import and_outputs_pkg_hdl::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
)
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_a,
    input  logic [WIDTH-1:0]         i_in_b,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH-1:0]         o_out_y,
`ifdef AND_OUTPUTS_PARITY_EN
    output logic                     o_out_par,
`endif
    input  logic                     i_flush,
    output logic [CNT_W-1:0]         o_txn_count,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int ENTRY_W = WIDTH + PAR_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_rdy_en;
    logic [CNT_W-1:0]   r_txn;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_and;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [LVL_W-1:0]   w_level;

    assign w_and = i_in_a & i_in_b;

`ifdef AND_OUTPUTS_PARITY_EN
    assign w_entry   = {^w_and, w_and};
    assign o_out_par = w_head[WIDTH];
`else
    assign w_entry   = w_and;
`endif

    assign w_push = i_in_valid && w_in_ready;
    assign w_pop  = w_out_valid && i_out_ready && !i_flush;

    // Holds in_ready low until the first clock after reset release
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs; a full buffer never accepts, even alongside a pop
    always_comb begin
        w_state_next = r_state;
        w_out_valid  = (r_state != EMPTY);
        w_in_ready   = r_rdy_en && (r_state != FULL) && !i_flush;
        if (i_flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (w_push && !w_pop && (w_level == LVL_LAST)) begin
                        w_state_next = FULL;
                    end else if (w_pop && !w_push && (w_level == LVL_ONE)) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_state_next = HOLD;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    // Accepted-transaction counter, saturating at all ones
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_txn <= '0;
        end else if (w_push && (r_txn != '1)) begin
            r_txn <= r_txn + 1'b1;
        end
    end

    and_outputs_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_level (w_level)
    );

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_y     = w_head[WIDTH-1:0];
    assign o_txn_count = r_txn;
    assign o_level     = w_level;

endmodule

// File: tb/tb_and_outputs_responder.sv
// tb/tb_and_outputs_responder.sv - scoreboard bench for and_outputs_responder
module tb_and_outputs_responder;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush     = 1'b0;
    logic [W-1:0]  in_a      = '0;
    logic [W-1:0]  in_b      = '0;
    logic [W-1:0]  exp_y     = '0;

    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_y;
    logic [CW-1:0] txn;
    logic [2:0]    level;
`ifdef AND_OUTPUTS_PARITY_EN
    logic          out_par;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_pop = 0;
    int            pop_base;
    logic [W-1:0]  sb_q [$];
    logic [W-1:0]  mon_e;

    and_outputs_responder #(
        .WIDTH (W),
        .DEPTH (D),
        .CNT_W (CW)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_y     (out_y),
`ifdef AND_OUTPUTS_PARITY_EN
        .o_out_par   (out_par),
`endif
        .i_flush     (flush),
        .o_txn_count (txn),
        .o_level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record the expected result whenever an operand pair is accepted
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back(exp_y);
        end
    end

    // Compare every result the consumer takes against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0h expected none at %0t", out_y, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_y", 32'(out_y), 32'(mon_e));
`ifdef AND_OUTPUTS_PARITY_EN
                check("out_par", 32'(out_par), 32'(^mon_e));
`endif
                n_pop++;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
        bit done = 0;
        in_a     = a;
        in_b     = b;
        exp_y    = e;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d queued expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values while reset is held
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_level", 32'(level), 0);
        check("rst_txn", 32'(txn), 0);
        check("rst_out_y", 32'(out_y), 0);
        rst_n = 1'b1;
        #1 check("rel_in_ready_before_clk", 32'(in_ready), 0);
        @(negedge clk);
        check("rel_in_ready_after_clk", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single transaction, one-cycle latency
        out_ready = 1'b1;
        send(4'hC, 4'hA, 4'h8);
        check("single_out_valid", 32'(out_valid), 1);
        check("single_out_y", 32'(out_y), 32'h8);
        check("single_txn", 32'(txn), 1);
        drain();

        // Fill to full, fifth pair refused, head stable while stalled
        out_ready = 1'b0;
        send(4'h1, 4'hF, 4'h1);
        send(4'h3, 4'h6, 4'h2);
        send(4'hF, 4'hF, 4'hF);
        send(4'h5, 4'hC, 4'h4);
        in_a = 4'hE; in_b = 4'h7; exp_y = 4'h6; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 0);
            check("full_level", 32'(level), 4);
            check("full_stall_out_y", 32'(out_y), 32'h1);
            check("full_stall_out_valid", 32'(out_valid), 1);
        end
        check("full_txn", 32'(txn), 5);
        @(posedge clk);
        #1 in_valid = 1'b0;
        pop_base  = n_pop;
        out_ready = 1'b1;
        drain();
        check("full_pops", 32'(n_pop - pop_base), 4);
        check("full_drained_level", 32'(level), 0);

        // Steady stream, one result per cycle, pointers wrap several times
        pop_base = n_pop;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_a  = 4'(i * 3 + 1);
            in_b  = 4'(15 - i);
            exp_y = in_a & in_b;
            @(negedge clk);
            if (i > 0) check("stream_level", 32'(level), 1);
            check("stream_in_ready", 32'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        check("stream_pops", 32'(n_pop - pop_base), 20);
        check("stream_txn", 32'(txn), 25);

        // Flush with three buffered entries and a push attempt in the same cycle
        out_ready = 1'b0;
        send(4'h9, 4'hC, 4'h8);
        send(4'h6, 4'h3, 4'h2);
        send(4'hA, 4'h5, 4'h0);
        check("preflush_level", 32'(level), 3);
        flush = 1'b1;
        in_a = 4'hF; in_b = 4'hF; exp_y = 4'hF; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("flush_level", 32'(level), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_txn", 32'(txn), 28);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(4'h9, 4'h3, 4'h1);
        drain();
        check("postflush_txn", 32'(txn), 29);

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        send(4'h7, 4'hE, 4'h6);
        send(4'hB, 4'hD, 4'h9);
        check("prereset_level", 32'(level), 2);
        check("prereset_out_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_level", 32'(level), 0);
        check("async_txn", 32'(txn), 0);
        check("async_in_ready", 32'(in_ready), 0);
        check("async_out_y", 32'(out_y), 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rerel_in_ready_before_clk", 32'(in_ready), 0);
        @(negedge clk);
        check("rerel_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

`ifdef AND_OUTPUTS_PARITY_EN
        // Parity stored alongside each result
        out_ready = 1'b1;
        send(4'hF, 4'h7, 4'h7);
        check("par1_out_y", 32'(out_y), 32'h7);
        check("par1_out_par", 32'(out_par), 1);
        send(4'h3, 4'h3, 4'h3);
        check("par0_out_y", 32'(out_y), 32'h3);
        check("par0_out_par", 32'(out_par), 0);
        drain();
`endif

        check("final_queue_empty", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/and_outputs_responder.md
Name: and_outputs_responder

Overview:
- Responder end of the AND_inputs operand interface.
- Accepts operand pairs (a, b) from the initiator through a valid/ready handshake, computes the bitwise AND, and buffers each result in a small FIFO.
- Returns results on an output valid/ready channel that the AND_outputs monitor/agent consumes.
- Sits between the operand stimulus path and the result-checking path of the AND gate testbench.

Parameters:
- WIDTH, 1, operand and result bit width (1..32).
- DEPTH, 4, result FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clock  input  1  single block clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  responder can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_y  output  WIDTH  result, in_a & in_b.
- flush  input  1  synchronous FIFO clear.
- txn_count  output  CNT_W  number of accepted operand pairs, saturating.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, rd_ptr=wr_ptr=0, level=0, out_valid=0, out_y=0, in_ready=0 while asserted, txn_count=0.
- First clock after reset deassertion: in_ready=1.
- Reset asserted mid-operation: all buffered results are discarded immediately; no partial transfer completes.
- Push: in_valid && in_ready at edge N writes {in_a & in_b} to the FIFO. out_valid is 1 at N+1 if the FIFO was empty, so latency is 1 cycle.
- Pop: out_valid && out_ready at an edge advances rd_ptr. out_y always shows the head entry; it is registered, with no combinational path from in_* to out_*.
- in_ready = (level < DEPTH) && !flush. There is no full-bypass: when full, a simultaneous pop does not enable a push in the same cycle.
- Simultaneous push and pop when not full and not empty: level unchanged, both pointers advance.
- Empty: out_valid=0 and out_y holds its last value. No same-cycle pass-through of an incoming push.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. Full/empty are derived from level, not from the pointers.
- Handshake rules:
  - out_y and out_valid stay stable while out_valid && !out_ready.
  - in_valid may drop without a handshake; no state change results.
- flush=1 at an edge: pointers and level go to 0 and out_valid goes to 0 next cycle. Any push or pop in that cycle is ignored. txn_count is unaffected.
- txn_count increments on every accepted push and saturates at 2^CNT_W-1 with no wrap.
- State machine:
  - EMPTY (level=0): push → HOLD.
  - HOLD (0<level<DEPTH): level drops to 0 → EMPTY; level reaches DEPTH → FULL.
  - FULL (level=DEPTH): pop → HOLD.
  - flush from any state → EMPTY.
  - out_valid = (state != EMPTY); in_ready = (state != FULL) && !flush.

Optional Feature:
- Macro: AND_OUTPUTS_PARITY_EN.
- Defined:
  - Adds output out_par (1 bit) = even parity (XOR reduction) of out_y.
  - The parity is computed at push time and stored alongside the result, so each FIFO entry is WIDTH+1 bits.
  - out_par follows the same stability rules as out_y.
  - Reset value of out_par is 0.
- Undefined: the port and the storage bit are absent; all other behaviour is identical.

Decomposition:
- Shared package and_outputs_pkg_hdl contains:
  - the result typedef (WIDTH data, plus a parity bit under the macro);
  - the state enum {EMPTY, HOLD, FULL};
  - constants for default WIDTH, DEPTH and CNT_W.
- One sub-module, and_outputs_fifo: storage array, pointers and level, with push/pop/flush inputs.
- The top level holds the AND, the FSM, the handshake logic and txn_count.

Test Plan:
- Reset, then WIDTH=4, push a=4'hC, b=4'hA with out_ready=1 → next cycle out_valid=1, out_y=4'h8; txn_count=1.
- DEPTH=4, out_ready=0, push 5 pairs back-to-back → in_ready=0 after the 4th accept, 5th not accepted, level=4, txn_count=4. Then out_ready=1 → results pop in FIFO order.
- Steady stream with in_valid=1 and out_ready=1 for 20 cycles → one result per cycle, level stays 1, pointers wrap correctly, no loss or duplication.
- Buffer holds 3 entries, pulse flush → level=0 and out_valid=0 next cycle, txn_count unchanged; push in the flush cycle is ignored.
- Assert reset while level=2 and out_valid=1 → out_valid=0 immediately (asynchronously), txn_count=0, in_ready=1 one clock after release.
- With AND_OUTPUTS_PARITY_EN, push a=4'hF, b=4'h7 → out_y=4'h7, out_par=1. Push a=4'h3, b=4'h3 → out_y=4'h3, out_par=0.
